// File: rtl/vga_output_stage_if.sv
// ---------------------------------------------------------------------------
// vga_output_stage_if
//
// Pixel bus between a sync/pixel generator and the VGA output stage.
//
// Signals (named from the output stage's point of view):
//   i_hsync, i_vsync   active-high syncs from the sync generator
//   i_visible          pixel lies in the active area
//   i_hpos, i_vpos     10-bit pixel coordinates
//   i_r, i_g, i_b      8-bit pixel colour
//   i_dither_set       load strobe for the dither-enable register
//   i_dither_val       value loaded when i_dither_set=1
//   o_vga_hsync/vsync  pin-level syncs
//   o_vga_red/grn/blu  3-bit pin-level colour
//   o_frame_start      one-cycle pulse at the start of each frame
//   o_frame_count      8-bit wrapping frame counter
//   o_dither_en        current dither-enable state
//
// Modports:
//   master  pixel source side (drives the i_* signals)
//   slave   output stage side (drives the o_* signals)
// ---------------------------------------------------------------------------
interface vga_output_stage_if;
    logic       i_hsync;
    logic       i_vsync;
    logic       i_visible;
    logic [9:0] i_hpos;
    logic [9:0] i_vpos;
    logic [7:0] i_r;
    logic [7:0] i_g;
    logic [7:0] i_b;
    logic       i_dither_set;
    logic       i_dither_val;
    logic       o_vga_hsync;
    logic       o_vga_vsync;
    logic [2:0] o_vga_red;
    logic [2:0] o_vga_grn;
    logic [2:0] o_vga_blu;
    logic       o_frame_start;
    logic [7:0] o_frame_count;
    logic       o_dither_en;

    modport master (
        output i_hsync, i_vsync, i_visible, i_hpos, i_vpos,
               i_r, i_g, i_b, i_dither_set, i_dither_val,
        input  o_vga_hsync, o_vga_vsync, o_vga_red, o_vga_grn, o_vga_blu,
               o_frame_start, o_frame_count, o_dither_en
    );

    modport slave (
        input  i_hsync, i_vsync, i_visible, i_hpos, i_vpos,
               i_r, i_g, i_b, i_dither_set, i_dither_val,
        output o_vga_hsync, o_vga_vsync, o_vga_red, o_vga_grn, o_vga_blu,
               o_frame_start, o_frame_count, o_dither_en
    );
endinterface

// File: rtl/vga_output_stage.sv
// ---------------------------------------------------------------------------
// vga_output_stage
//
// Two-stage registered VGA output path: ordered (Bayer 4x4) dithering of
// 8-bit colour down to 3-bit pins, blanking outside the active area,
// optional sync inversion and frame-start detection / counting.
//
// Parameters:
//   INVERT_SYNC     1 = pin syncs are the inverse of the input syncs
//   DITHER_DEFAULT  dither-enable value loaded on reset
//
// Ports:
//   i_clk    pixel clock, the only clock
//   i_reset  synchronous active-high reset
//   bus      pixel bus (vga_output_stage_if.slave)
//
// Latency is 2 cycles for syncs, colour and frame_start alike.
// ---------------------------------------------------------------------------
module vga_output_stage #(
    parameter bit INVERT_SYNC    = 1'b0,
    parameter bit DITHER_DEFAULT = 1'b1
) (
    input logic               i_clk,
    input logic               i_reset,
    vga_output_stage_if.slave bus
);

    // Bayer matrix flattened as {row, col} = {vpos[1:0], hpos[1:0]}
    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    logic [7:0] colour_in [3];
    logic [8:0] sum_d     [3];
    logic [8:0] sum_q     [3];
    logic [2:0] quant_d   [3];
    logic [2:0] colour_q  [3];

    logic       hsync_s1_q, vsync_s1_q, visible_s1_q, edge_s1_q;
    logic       hsync_o_q, vsync_o_q, frame_start_q;
    logic [7:0] frame_count_q, frame_count_d;
    logic       dither_en_q, dither_en_d;
    logic       armed_q, armed_d;
    logic       edge_d;
    logic [3:0] threshold_d;
    logic       unused_pos_bits;

    // Only the low two coordinate bits select the matrix cell.
    assign unused_pos_bits = ^{bus.i_hpos[9:2], bus.i_vpos[9:2]};

    assign colour_in[0] = bus.i_r;
    assign colour_in[1] = bus.i_g;
    assign colour_in[2] = bus.i_b;

    always_comb begin
        threshold_d   = dither_en_q ? BAYER[{bus.i_vpos[1:0], bus.i_hpos[1:0]}] : 4'd0;
        dither_en_d   = bus.i_dither_set ? bus.i_dither_val : dither_en_q;
        // armed_q records that a low vsync has been sampled since reset, so a
        // vsync already high at reset release cannot count as a rising edge.
        armed_d       = armed_q | ~bus.i_vsync;
        edge_d        = bus.i_vsync & ~vsync_s1_q & armed_q;
        frame_count_d = frame_count_q + {7'd0, edge_s1_q};
    end

    // Per-channel dither add (stage 1) and saturate/blank (stage 2)
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign sum_d[gi]   = {1'b0, colour_in[gi]} + {4'd0, threshold_d, 1'b0};
            assign quant_d[gi] = !visible_s1_q       ? 3'd0 :
                                 (sum_q[gi] > 9'd255) ? 3'd7 : sum_q[gi][7:5];

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    sum_q[gi]    <= 9'd0;
                    colour_q[gi] <= 3'd0;
                end else begin
                    sum_q[gi]    <= sum_d[gi];
                    colour_q[gi] <= quant_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hsync_s1_q    <= 1'b0;
            vsync_s1_q    <= 1'b0;
            visible_s1_q  <= 1'b0;
            edge_s1_q     <= 1'b0;
            armed_q       <= 1'b0;
            hsync_o_q     <= INVERT_SYNC;
            vsync_o_q     <= INVERT_SYNC;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
            dither_en_q   <= DITHER_DEFAULT;
        end else begin
            hsync_s1_q    <= bus.i_hsync;
            vsync_s1_q    <= bus.i_vsync;
            visible_s1_q  <= bus.i_visible;
            edge_s1_q     <= edge_d;
            armed_q       <= armed_d;
            hsync_o_q     <= hsync_s1_q ^ INVERT_SYNC;
            vsync_o_q     <= vsync_s1_q ^ INVERT_SYNC;
            frame_start_q <= edge_s1_q;
            frame_count_q <= frame_count_d;
            dither_en_q   <= dither_en_d;
        end
    end

    assign bus.o_vga_hsync   = hsync_o_q;
    assign bus.o_vga_vsync   = vsync_o_q;
    assign bus.o_vga_red     = colour_q[0];
    assign bus.o_vga_grn     = colour_q[1];
    assign bus.o_vga_blu     = colour_q[2];
    assign bus.o_frame_start = frame_start_q;
    assign bus.o_frame_count = frame_count_q;
    assign bus.o_dither_en   = dither_en_q;

endmodule

// File: tb/tb_vga_output_stage.sv
module tb_vga_output_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vga_output_stage_if vif0();
    vga_output_stage_if vif1();

    vga_output_stage #(.INVERT_SYNC(1'b0), .DITHER_DEFAULT(1'b1)) dut0 (
        .i_clk(clk), .i_reset(rst), .bus(vif0)
    );
    vga_output_stage #(.INVERT_SYNC(1'b1), .DITHER_DEFAULT(1'b0)) dut1 (
        .i_clk(clk), .i_reset(rst), .bus(vif1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hs, input logic vs, input logic vis,
                         input logic [9:0] hp, input logic [9:0] vp,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        vif0.i_hsync = hs;  vif1.i_hsync = hs;
        vif0.i_vsync = vs;  vif1.i_vsync = vs;
        vif0.i_visible = vis; vif1.i_visible = vis;
        vif0.i_hpos = hp;   vif1.i_hpos = hp;
        vif0.i_vpos = vp;   vif1.i_vpos = vp;
        vif0.i_r = r; vif1.i_r = r;
        vif0.i_g = g; vif1.i_g = g;
        vif0.i_b = b; vif1.i_b = b;
    endtask

    task automatic set_dither(input logic set, input logic val);
        vif0.i_dither_set = set; vif1.i_dither_set = set;
        vif0.i_dither_val = val; vif1.i_dither_val = val;
    endtask

    task automatic set_vsync(input logic vs);
        vif0.i_vsync = vs;
        vif1.i_vsync = vs;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_dither(1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 10'd5, 10'd5, 8'hFF, 8'hFF, 8'hFF);
        step();
        step();
        n_checks++;
        if ({vif0.o_vga_red, vif0.o_vga_grn, vif0.o_vga_blu} !== 9'd0) begin
            n_fail++; $display("FAIL reset_colour0 got %h want 000", {vif0.o_vga_red, vif0.o_vga_grn, vif0.o_vga_blu});
        end
        n_checks++;
        if ({vif0.o_vga_hsync, vif0.o_vga_vsync} !== 2'b00) begin
            n_fail++; $display("FAIL reset_sync0 got %b want 00", {vif0.o_vga_hsync, vif0.o_vga_vsync});
        end
        n_checks++;
        if ({vif1.o_vga_hsync, vif1.o_vga_vsync} !== 2'b11) begin
            n_fail++; $display("FAIL reset_sync1 got %b want 11", {vif1.o_vga_hsync, vif1.o_vga_vsync});
        end
        n_checks++;
        if ({vif0.o_frame_start, vif0.o_frame_count} !== 9'd0) begin
            n_fail++; $display("FAIL reset_frame0 got fs=%b cnt=%0d want 0/0", vif0.o_frame_start, vif0.o_frame_count);
        end
        n_checks++;
        if ({vif0.o_dither_en, vif1.o_dither_en} !== 2'b10) begin
            n_fail++; $display("FAIL reset_dither got %b want 10", {vif0.o_dither_en, vif1.o_dither_en});
        end
        $display("test_reset done");
    endtask

    task automatic test_no_dither();
        // vsync stays high across release: must not count as a frame start
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 8'hFF, 8'h80, 8'h1F);
        set_dither(1'b1, 1'b0);
        step();
        n_checks++;
        if (vif0.o_frame_start !== 1'b0) begin
            n_fail++; $display("FAIL nodither_fs_a got %b want 0", vif0.o_frame_start);
        end
        set_dither(1'b0, 1'b0);
        step();
        n_checks++;
        if (vif0.o_frame_start !== 1'b0) begin
            n_fail++; $display("FAIL nodither_fs_b got %b want 0", vif0.o_frame_start);
        end
        step();
        n_checks++;
        if ({vif0.o_vga_red, vif0.o_vga_grn, vif0.o_vga_blu} !== {3'd7, 3'd4, 3'd0}) begin
            n_fail++; $display("FAIL nodither_rgb got %0d/%0d/%0d want 7/4/0", vif0.o_vga_red, vif0.o_vga_grn, vif0.o_vga_blu);
        end
        n_checks++;
        if ({vif0.o_dither_en, vif1.o_dither_en} !== 2'b00) begin
            n_fail++; $display("FAIL nodither_en got %b want 00", {vif0.o_dither_en, vif1.o_dither_en});
        end
        $display("test_no_dither done");
    endtask

    task automatic test_dither_load();
        // load dither on in the same cycle the pixel enters: that pixel uses T=0
        drive(1'b0, 1'b0, 1'b1, 10'd0, 10'd3, 8'h1F, 8'h00, 8'h00);
        set_dither(1'b1, 1'b1);
        step();
        set_dither(1'b0, 1'b0);
        step();
        n_checks++;
        if (vif0.o_vga_red !== 3'd0) begin
            n_fail++; $display("FAIL dload_old got %0d want 0", vif0.o_vga_red);
        end
        step();
        n_checks++;
        if (vif0.o_vga_red !== 3'd1) begin
            n_fail++; $display("FAIL dload_new got %0d want 1", vif0.o_vga_red);
        end
        n_checks++;
        if ({vif0.o_dither_en, vif1.o_dither_en, vif1.o_vga_red} !== {2'b11, 3'd1}) begin
            n_fail++; $display("FAIL dload_dut1 got en=%b%b red=%0d want 11/1", vif0.o_dither_en, vif1.o_dither_en, vif1.o_vga_red);
        end
        $display("test_dither_load done");
    endtask

    task automatic test_dither_vectors();
        logic [9:0] hp [6] = '{10'd0, 10'd0, 10'd2, 10'd3, 10'd1, 10'd3};
        logic [9:0] vp [6] = '{10'd0, 10'd3, 10'd1, 10'd2, 10'd1, 10'd3};
        logic [7:0] r  [6] = '{8'h1F, 8'hFF, 8'h00, 8'h00, 8'h80, 8'hE0};
        logic [7:0] g  [6] = '{8'h00, 8'h00, 8'hF0, 8'h00, 8'h80, 8'h1F};
        logic [7:0] b  [6] = '{8'h00, 8'h00, 8'h00, 8'h50, 8'h80, 8'h10};
        logic [8:0] exp_rgb [6] = '{{3'd0,3'd0,3'd0}, {3'd7,3'd0,3'd0}, {3'd0,3'd7,3'd0},
                                    {3'd0,3'd0,3'd3}, {3'd4,3'd4,3'd4}, {3'd7,3'd1,3'd0}};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, hp[i], vp[i], r[i], g[i], b[i]);
            step();
            step();
            n_checks++;
            if ({vif0.o_vga_red, vif0.o_vga_grn, vif0.o_vga_blu} !== exp_rgb[i]) begin
                n_fail++;
                $display("FAIL dither_vec%0d got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         vif0.o_vga_red, vif0.o_vga_grn, vif0.o_vga_blu,
                         exp_rgb[i][8:6], exp_rgb[i][5:3], exp_rgb[i][2:0]);
            end
        end
        $display("test_dither_vectors done");
    endtask

    task automatic test_blank_sync();
        drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd3, 8'hFF, 8'hFF, 8'hFF);
        step();
        n_checks++;
        if ({vif0.o_vga_hsync, vif1.o_vga_hsync} !== 2'b01) begin
            n_fail++; $display("FAIL blank_hs_lat got %b want 01", {vif0.o_vga_hsync, vif1.o_vga_hsync});
        end
        step();
        n_checks++;
        if ({vif0.o_vga_hsync, vif1.o_vga_hsync} !== 2'b10) begin
            n_fail++; $display("FAIL blank_hs got %b want 10", {vif0.o_vga_hsync, vif1.o_vga_hsync});
        end
        n_checks++;
        if ({vif0.o_vga_red, vif0.o_vga_grn, vif0.o_vga_blu} !== 9'd0) begin
            n_fail++; $display("FAIL blank_rgb0 got %h want 000", {vif0.o_vga_red, vif0.o_vga_grn, vif0.o_vga_blu});
        end
        n_checks++;
        if ({vif1.o_vga_red, vif1.o_vga_grn, vif1.o_vga_blu, vif1.o_vga_vsync} !== 10'b1) begin
            n_fail++; $display("FAIL blank_rgb1 got %h vs=%b want 000/1", {vif1.o_vga_red, vif1.o_vga_grn, vif1.o_vga_blu}, vif1.o_vga_vsync);
        end
        drive(1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 8'h00, 8'h00, 8'h00);
        step();
        step();
        $display("test_blank_sync done");
    endtask

    task automatic test_frames();
        int pulses = 0;
        int wide = 0;
        int misaligned = 0;
        logic prev_fs = 1'b0;
        n_checks++;
        if (vif0.o_frame_count !== 8'd0) begin
            n_fail++; $display("FAIL frames_start got %0d want 0", vif0.o_frame_count);
        end
        for (int i = 0; i < 2 * 257 + 3; i++) begin
            set_vsync((i < 2 * 257) && (i % 2 == 0));
            step();
            if (vif0.o_frame_start) begin
                pulses++;
                if (prev_fs) wide++;
                if (!vif0.o_vga_vsync) misaligned++;
            end
            prev_fs = vif0.o_frame_start;
        end
        n_checks++;
        if (pulses !== 257) begin
            n_fail++; $display("FAIL frames_pulses got %0d want 257", pulses);
        end
        n_checks++;
        if ({wide, misaligned} !== 64'd0) begin
            n_fail++; $display("FAIL frames_shape got wide=%0d misaligned=%0d want 0/0", wide, misaligned);
        end
        n_checks++;
        if ({vif0.o_frame_count, vif1.o_frame_count} !== {8'd1, 8'd1}) begin
            n_fail++; $display("FAIL frames_count got %0d/%0d want 1/1", vif0.o_frame_count, vif1.o_frame_count);
        end
        // held-high vsync: exactly one pulse, two cycles after the edge
        set_vsync(1'b1);
        step();
        n_checks++;
        if (vif0.o_frame_start !== 1'b0) begin
            n_fail++; $display("FAIL held_lat got %b want 0", vif0.o_frame_start);
        end
        step();
        n_checks++;
        if ({vif0.o_frame_start, vif0.o_vga_vsync} !== 2'b11) begin
            n_fail++; $display("FAIL held_pulse got fs=%b vs=%b want 1/1", vif0.o_frame_start, vif0.o_vga_vsync);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (vif0.o_frame_start) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL held_extra got %0d want 0", pulses);
        end
        n_checks++;
        if (vif0.o_frame_count !== 8'd2) begin
            n_fail++; $display("FAIL held_count got %0d want 2", vif0.o_frame_count);
        end
        set_vsync(1'b0);
        step();
        step();
        step();
        $display("test_frames done");
    endtask

    task automatic test_mid_reset();
        int pulses = 0;
        drive(1'b1, 1'b1, 1'b1, 10'd0, 10'd3, 8'hFF, 8'hFF, 8'hFF);
        step();
        step();
        step();
        n_checks++;
        if ({vif0.o_vga_red, vif0.o_vga_hsync} !== {3'd7, 1'b1}) begin
            n_fail++; $display("FAIL mrst_pre got red=%0d hs=%b want 7/1", vif0.o_vga_red, vif0.o_vga_hsync);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({vif0.o_vga_red, vif0.o_vga_grn, vif0.o_vga_blu, vif0.o_vga_hsync, vif0.o_vga_vsync,
             vif0.o_frame_start, vif0.o_frame_count, vif0.o_dither_en} !== {9'd0, 2'b00, 1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL mrst_dut0 got rgb=%h hs=%b vs=%b fs=%b cnt=%0d en=%b want 000/0/0/0/0/1",
                     {vif0.o_vga_red, vif0.o_vga_grn, vif0.o_vga_blu}, vif0.o_vga_hsync, vif0.o_vga_vsync,
                     vif0.o_frame_start, vif0.o_frame_count, vif0.o_dither_en);
        end
        n_checks++;
        if ({vif1.o_vga_hsync, vif1.o_vga_vsync, vif1.o_frame_count, vif1.o_dither_en} !== {2'b11, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mrst_dut1 got hs=%b vs=%b cnt=%0d en=%b want 1/1/0/0",
                     vif1.o_vga_hsync, vif1.o_vga_vsync, vif1.o_frame_count, vif1.o_dither_en);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({vif0.o_vga_red, vif0.o_frame_start} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL mrst_lat got red=%0d fs=%b want 0/0", vif0.o_vga_red, vif0.o_frame_start);
        end
        step();
        n_checks++;
        if ({vif0.o_vga_red, vif0.o_vga_vsync, vif0.o_frame_start} !== {3'd7, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL mrst_resume got red=%0d vs=%b fs=%b want 7/1/0", vif0.o_vga_red, vif0.o_vga_vsync, vif0.o_frame_start);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (vif0.o_frame_start) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL mrst_nopulse got %0d want 0", pulses);
        end
        set_vsync(1'b0);
        step();
        set_vsync(1'b1);
        step();
        step();
        n_checks++;
        if ({vif0.o_frame_start, vif0.o_frame_count} !== {1'b1, 8'd1}) begin
            n_fail++; $display("FAIL mrst_first got fs=%b cnt=%0d want 1/1", vif0.o_frame_start, vif0.o_frame_count);
        end
        $display("test_mid_reset done");
    endtask

    initial begin
        test_reset();
        test_no_dither();
        test_dither_load();
        test_dither_vectors();
        test_blank_sync();
        test_frames();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
